ap_result_collector: RTL and testbench

- Downstream consumer of the dot-product stage.
- Captures each scalar `result` qualified by its one-cycle `finish` pulse and packs no_of_units consecutive results into one memory word.
- Writes packed words into the AP_total memory through a we/ready handshake, then flags completion of the AP vector for the cluster.
- Throttles the upstream row feeder via `outsider_read_now`.

---
 rtl/ap_result_collector.sv | 152 +++++++++++++++
 tb/tb_ap_result_collector.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_result_collector.sv
// Packs finish-qualified dot-product results into AP_total memory words and flags vector completion.
// Optional one-entry skid buffer for results arriving during a write: define AP_COLLECT_SKID_EN.
module ap_result_collector #(
    parameter int number_of_equations_per_cluster = 16,
    parameter int element_width                   = 32,
    parameter int no_of_units                     = 8,
    parameter int addr_width                      = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [element_width-1:0]               result,
    input  logic                                   finish,
    input  logic                                   mem_ready,
    output logic                                   AP_total_mem_we,
    output logic [addr_width-1:0]                  AP_total_mem_addr,
    output logic [element_width*no_of_units-1:0]   AP_total_mem_data,
    output logic                                   outsider_read_now,
    output logic [31:0]                            elem_count,
    output logic                                   done,
    output logic                                   overflow
);
    localparam int WORD_W = element_width * no_of_units;
    localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;
    localparam logic [31:0] TOTAL = 32'(number_of_equations_per_cluster);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(no_of_units - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
    state_t state, state_nxt;

    logic [LANE_W-1:0]        lane;
    logic [WORD_W-1:0]        buffer, buffer_nxt;
    logic [addr_width-1:0]    addr;
    logic [31:0]              count;
    logic                     ovf;

    logic                     restart, accept, drop, write_done, final_word, end_of_word;
    logic [element_width-1:0] accept_data;

`ifdef AP_COLLECT_SKID_EN
    logic                     skid_vld;
    logic [element_width-1:0] skid;
    logic                     skid_load;
`endif

    always_comb begin
        restart    = start && (state == IDLE || state == DONE);
        write_done = (state == WRITE) && mem_ready;
        final_word = (count == TOTAL);
`ifdef AP_COLLECT_SKID_EN
        // A held skid entry drains first; a coincident finish refills the skid.
        accept      = (state == COLLECT) && (skid_vld || finish);
        accept_data = skid_vld ? skid : result;
        skid_load   = finish && ((state == COLLECT && skid_vld) ||
                                 (state == WRITE && !skid_vld && !final_word));
        drop        = finish && (state != COLLECT) && !skid_load;
`else
        accept      = (state == COLLECT) && finish;
        accept_data = result;
        drop        = finish && (state != COLLECT);
`endif
        end_of_word = accept && ((lane == LAST_LANE) || (count == TOTAL - 32'd1));
    end

    // Element 0 lands in the most-significant lane; unfilled lanes stay zero from the clear.
    always_comb begin
        buffer_nxt = buffer;
        for (int i = 0; i < no_of_units; i++) begin
            if (accept && lane == LANE_W'(i))
                buffer_nxt[element_width*(no_of_units-1-i) +: element_width] = accept_data;
        end
        if (write_done)
            buffer_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = COLLECT;
            COLLECT:    if (end_of_word) state_nxt = WRITE;
            WRITE:      if (mem_ready) state_nxt = final_word ? DONE : COLLECT;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane   <= '0;
            buffer <= '0;
            addr   <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (restart) begin
            lane   <= '0;
            buffer <= '0;
            addr   <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            buffer <= buffer_nxt;
            if (accept) begin
                count <= count + 32'd1;
                lane  <= lane + LANE_W'(1);
            end
            if (write_done) begin
                lane <= '0;
                addr <= addr + addr_width'(1);
            end
            if (drop)
                ovf <= 1'b1;
        end
    end

`ifdef AP_COLLECT_SKID_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_vld <= 1'b0;
            skid     <= '0;
        end else if (restart) begin
            skid_vld <= 1'b0;
        end else if (skid_load) begin
            skid     <= result;
            skid_vld <= 1'b1;
        end else if (accept && skid_vld) begin
            skid_vld <= 1'b0;
        end
    end
`endif

    always_comb begin
        AP_total_mem_we   = (state == WRITE);
        done              = (state == DONE);
`ifdef AP_COLLECT_SKID_EN
        outsider_read_now = (state == COLLECT) ||
                            (state == WRITE && !skid_vld && !final_word);
`else
        outsider_read_now = (state == COLLECT);
`endif
        AP_total_mem_addr = addr;
        AP_total_mem_data = buffer;
        elem_count        = count;
        overflow          = ovf;
    end

endmodule

// File: tb/tb_ap_result_collector.sv
// Directed bench for ap_result_collector: default 16-element instance plus a 10-element instance.
module tb_ap_result_collector;
    localparam int DW = 256;
`ifdef AP_COLLECT_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start, finish, mem_ready;
    logic [31:0]   result;

    logic          we, rd, dn, ovf;
    logic [7:0]    addr;
    logic [DW-1:0] data;
    logic [31:0]   cnt;

    logic          we10, rd10, dn10, ovf10;
    logic [7:0]    addr10;
    logic [DW-1:0] data10;
    logic [31:0]   cnt10;

    ap_result_collector dut (
        .clk(clk), .reset(reset), .start(start), .result(result), .finish(finish),
        .mem_ready(mem_ready), .AP_total_mem_we(we), .AP_total_mem_addr(addr),
        .AP_total_mem_data(data), .outsider_read_now(rd), .elem_count(cnt),
        .done(dn), .overflow(ovf)
    );

    ap_result_collector #(.number_of_equations_per_cluster(10)) dut10 (
        .clk(clk), .reset(reset), .start(start), .result(result), .finish(finish),
        .mem_ready(mem_ready), .AP_total_mem_we(we10), .AP_total_mem_addr(addr10),
        .AP_total_mem_data(data10), .outsider_read_now(rd10), .elem_count(cnt10),
        .done(dn10), .overflow(ovf10)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]    log_addr[64];
    logic [DW-1:0] log_data[64];
    int            nw = 0;
    logic [7:0]    log10_addr[64];
    logic [DW-1:0] log10_data[64];
    int            nw10 = 0;

    // Record every accepted memory write as the memory itself would see it.
    always @(posedge clk) begin
        if (reset && we && mem_ready && nw < 64) begin
            log_addr[nw] = addr;
            log_data[nw] = data;
            nw = nw + 1;
        end
        if (reset && we10 && mem_ready && nw10 < 64) begin
            log10_addr[nw10] = addr10;
            log10_data[nw10] = data10;
            nw10 = nw10 + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] v);
        finish = 1'b1;
        result = v;
        @(negedge clk);
        finish = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] push(input logic [DW-1:0] w, input logic [31:0] v);
        return {w[DW-33:0], v};
    endfunction

    initial begin
        logic [DW-1:0] e0, e1;
        int base, base10;

        reset = 1'b0; start = 1'b0; finish = 1'b0; result = '0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_we",   DW'(we),   DW'(0));
        check("rst_addr", DW'(addr), DW'(0));
        check("rst_data", data,      DW'(0));
        check("rst_rd",   DW'(rd),   DW'(0));
        check("rst_cnt",  DW'(cnt),  DW'(0));
        check("rst_done", DW'(dn),   DW'(0));
        check("rst_ovf",  DW'(ovf),  DW'(0));
        reset = 1'b1;
        @(negedge clk);

        e0 = '0;
        for (int i = 1; i <= 8; i++) e0 = push(e0, 32'(i));
        e1 = '0;
        for (int i = 9; i <= 16; i++) e1 = push(e1, 32'(i));

        // Full 16-element vector, memory always ready.
        base = nw;
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            send(32'(i));
            tick();
        end
        tick();
        check("t1_nwrites", DW'(nw - base),        DW'(2));
        check("t1_addr0",   DW'(log_addr[base]),   DW'(0));
        check("t1_addr1",   DW'(log_addr[base+1]), DW'(1));
        check("t1_word0",   log_data[base],        e0);
        check("t1_word1",   log_data[base+1],      e1);
        check("t1_done",    DW'(dn),               DW'(1));
        check("t1_cnt",     DW'(cnt),              DW'(16));
        check("t1_ovf",     DW'(ovf),              DW'(0));
        send(32'h77);
        tick();
        check("t1_done_ovf", DW'(ovf), DW'(1));
        check("t1_done_cnt", DW'(cnt), DW'(16));

        // 10-element vector: last word carries two elements and six zero pad lanes.
        do_reset();
        base10 = nw10;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send(32'hA0 + 32'(i));
            if (i < 9) tick();
        end
        check("t2_we_last",   DW'(we10), DW'(1));
        check("t2_done_early", DW'(dn10), DW'(0));
        tick();
        tick();
        e0 = '0;
        for (int i = 0; i < 8; i++) e0 = push(e0, 32'hA0 + 32'(i));
        e1 = '0;
        e1 = push(e1, 32'hA8);
        e1 = push(e1, 32'hA9);
        for (int i = 0; i < 6; i++) e1 = push(e1, 32'h0);
        check("t2_nwrites", DW'(nw10 - base10),        DW'(2));
        check("t2_addr1",   DW'(log10_addr[base10+1]), DW'(1));
        check("t2_word0",   log10_data[base10],        e0);
        check("t2_word1",   log10_data[base10+1],      e1);
        check("t2_done",    DW'(dn10),                 DW'(1));
        check("t2_cnt",     DW'(cnt10),                DW'(10));
        check("t2_ovf",     DW'(ovf10),                DW'(0));

        e0 = '0;
        for (int i = 1; i <= 8; i++) e0 = push(e0, 32'(i));
        e1 = '0;
        for (int i = 9; i <= 16; i++) e1 = push(e1, 32'(i));

        // Memory stalls the first write for five edges.
        do_reset();
        mem_ready = 1'b0;
        base = nw;
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            send(32'(i));
            if (i < 8) tick();
        end
        check("t3_rd_write", DW'(rd), DW'(SKID));
        for (int k = 0; k < 6; k++) begin
            check("t3_we_hold",   DW'(we),   DW'(1));
            check("t3_data_hold", data,      e0);
            check("t3_addr_hold", DW'(addr), DW'(0));
            if (k < 5) tick();
        end
        check("t3_nw_stall", DW'(nw - base), DW'(0));
        mem_ready = 1'b1;
        tick();
        check("t3_we_drop", DW'(we),        DW'(0));
        check("t3_addr_inc", DW'(addr),     DW'(1));
        check("t3_nw_one",  DW'(nw - base), DW'(1));
        for (int i = 9; i <= 16; i++) begin
            send(32'(i));
            tick();
        end
        tick();
        check("t3_nwrites", DW'(nw - base),        DW'(2));
        check("t3_addr1",   DW'(log_addr[base+1]), DW'(1));
        check("t3_word1",   log_data[base+1],      e1);
        check("t3_done",    DW'(dn),               DW'(1));

        // Result arrives while a write is pending.
        do_reset();
        mem_ready = 1'b0;
        base = nw;
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            send(32'(i));
            if (i < 8) tick();
        end
        send(32'h55);
        mem_ready = 1'b1;
        tick();
        tick();
        check("t4_ovf", DW'(ovf), DW'(!SKID));
        check("t4_cnt", DW'(cnt), SKID ? DW'(9) : DW'(8));
        e1 = '0;
        if (SKID) e1 = push(e1, 32'h55);
        for (int i = 9; i <= (SKID ? 15 : 16); i++) begin
            e1 = push(e1, 32'(i));
            send(32'(i));
            tick();
        end
        tick();
        check("t4_nwrites", DW'(nw - base),   DW'(2));
        check("t4_word0",   log_data[base],   e0);
        check("t4_word1",   log_data[base+1], e1);
        check("t4_done",    DW'(dn),          DW'(1));
        check("t4_cnt_end", DW'(cnt),         DW'(16));
        check("t4_ovf_end", DW'(ovf),         DW'(!SKID));

        // Asynchronous reset while a write is being presented.
        do_reset();
        mem_ready = 1'b0;
        pulse_start();
        for (int i = 1; i <= 8; i++) begin
            send(32'(i));
            if (i < 8) tick();
        end
        check("t5_we_pre", DW'(we), DW'(1));
        reset = 1'b0;
        #1;
        check("t5_we",   DW'(we),   DW'(0));
        check("t5_addr", DW'(addr), DW'(0));
        check("t5_data", data,      DW'(0));
        check("t5_rd",   DW'(rd),   DW'(0));
        check("t5_cnt",  DW'(cnt),  DW'(0));
        check("t5_done", DW'(dn),   DW'(0));
        check("t5_ovf",  DW'(ovf),  DW'(0));
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        base = nw;
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            send(32'(i));
            tick();
        end
        tick();
        check("t5_nwrites", DW'(nw - base),      DW'(2));
        check("t5_addr0",   DW'(log_addr[base]), DW'(0));
        check("t5_word0",   log_data[base],      e0);
        check("t5_done",    DW'(dn),             DW'(1));

        // Start pulse in the middle of collection is ignored.
        do_reset();
        base = nw;
        pulse_start();
        for (int i = 1; i <= 3; i++) begin
            send(32'(i));
            tick();
        end
        pulse_start();
        check("t6_cnt_mid", DW'(cnt), DW'(3));
        check("t6_rd_mid",  DW'(rd),  DW'(1));
        for (int i = 4; i <= 16; i++) begin
            send(32'(i));
            tick();
        end
        tick();
        check("t6_nwrites", DW'(nw - base),   DW'(2));
        check("t6_word0",   log_data[base],   e0);
        check("t6_word1",   log_data[base+1], e1);
        check("t6_cnt",     DW'(cnt),         DW'(16));
        check("t6_done",    DW'(dn),          DW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
